// File: rtl/pulse_sched_pkg.sv
// Shared types and width helpers for the pulse scheduler and its arbiter.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wait counter must hold the larger of GAP and TMO.
  function automatic int cnt_w(input int gap, input int tmo);
    int m;
    m = (gap > tmo) ? gap : tmo;
    return (m > 1) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/pulse_sched_rr_arbiter.sv
// Round-robin pick among pending bits, searching upward from ptr with wraparound.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] pend,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int c;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int off = 0; off < NREQ; off++) begin
      c = int'(ptr) + off;
      if (c >= NREQ) c = c - NREQ;
      if (!valid && pend[c]) begin
        valid    = 1'b1;
        idx      = IW'(c);
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Serialises event requests from NREQ sources onto one shared pulse synchronizer,
// spacing pulses by a fixed gap or by the destination's acknowledge.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int GAP      = 6,
  parameter int ACK_MODE = 0,
  parameter int TMO      = 64,
  parameter int OVF_W    = 8,
  parameter int IW       = idx_w(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_i,
  input  logic             ack_i,
  input  logic             clr_i,
  output logic             pulse_o,
  output logic [IW-1:0]    id_o,
  output logic             busy_o,
  output logic [NREQ-1:0]  pend_o,
  output logic [OVF_W-1:0] ovf_cnt_o,
  output logic             err_o,
  output state_e           state_o
);

  localparam int CW = cnt_w(GAP, TMO);
  localparam int SW = OVF_W + IW + 1;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   pend_q, pend_d, clr_mask, ovf_bits, grant;
  logic [IW-1:0]     ptr_q, gidx;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     pop, sum;
  logic [OVF_W-1:0]  ovf_d;
  logic              gvalid, issue, timeout, err_d;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .pend  (pend_q),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx),
    .valid (gvalid)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (gvalid) begin
          state_d = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ACK_MODE == 0) begin
          if (cnt_q == CW'(GAP - 1)) state_d = IDLE;
        end else if (ack_i) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(TMO - 1)) begin
          state_d = IDLE;
          timeout = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A request landing on the bit being granted refills it rather than overflowing.
  always_comb begin
    clr_mask = issue ? grant : '0;
    ovf_bits = req_i & pend_q & ~clr_mask;
    pend_d   = (pend_q & ~clr_mask) | req_i;
    cnt_d    = (state_q == WAIT) ? cnt_q + CW'(1) : '0;
    pop      = '0;
    for (int i = 0; i < NREQ; i++) pop = pop + SW'(ovf_bits[i]);
    sum      = SW'(ovf_cnt_o) + pop;
    ovf_d    = (sum > SW'(OVF_MAX)) ? OVF_MAX : sum[OVF_W-1:0];
    err_d    = err_o | timeout;
    if (clr_i) begin
      ovf_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      pulse_o   <= 1'b0;
      id_o      <= '0;
      busy_o    <= 1'b0;
      ovf_cnt_o <= '0;
      err_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      pulse_o   <= issue;
      busy_o    <= (state_d != IDLE);
      ovf_cnt_o <= ovf_d;
      err_o     <= err_d;
      if (issue) begin
        id_o  <= gidx;
        ptr_q <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
      end
    end
  end

  assign pend_o  = pend_q;
  assign state_o = state_q;

endmodule
